// File: rtl/ram16_arb_fifo_pkg.sv
// rtl/ram16_arb_fifo_pkg.sv - source-channel type and round-robin pick helper
// Purpose: shared types for the two-channel arbiter FIFO.
// Contents: src_e (source channel tag), arb_pick() (round-robin channel choice).
package ram16_arb_fifo_pkg;

  typedef enum logic {
    SRC_CH0 = 1'b0,
    SRC_CH1 = 1'b1
  } src_e;

  // One requester wins outright; with both requesting, rr names the winner.
  function automatic src_e arb_pick(input logic v0, input logic v1, input logic rr);
    if (v0 && v1) begin
      return rr ? SRC_CH1 : SRC_CH0;
    end
    return v1 ? SRC_CH1 : SRC_CH0;
  endfunction

endpackage

// File: rtl/ram16_arb_fifo_ram.sv
// rtl/ram16_arb_fifo_ram.sv - distributed RAM, one write port, async read ports
// Purpose: word storage for the arbiter FIFO.
// Ports: clk_i clock; we_i write enable; aw_i write address; ar_i read address;
//        d_i write data; qw_o data at aw_i; qr_o data at ar_i (both combinational).
module myRAM_WxD_D #(
  parameter int DATA_WIDTH = 17,
  parameter int DATA_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DATA_DEPTH-1:0] aw_i,
  input  logic [DATA_DEPTH-1:0] ar_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] qw_o,
  output logic [DATA_WIDTH-1:0] qr_o
);

  localparam int DEPTH = 1 << DATA_DEPTH;

  // No reset: contents are don't-care until written.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[aw_i] <= d_i;
    end
  end

  assign qw_o = mem_q[aw_i];
  assign qr_o = mem_q[ar_i];

endmodule

// File: rtl/ram16_arb_fifo.sv
// rtl/ram16_arb_fifo.sv - two-channel round-robin write arbiter feeding a RAM FIFO
// Purpose: merges two valid/ready producer streams into one ordered, source-tagged stream.
// Ports: clk, rst_n (sync, active low); req0_*/req1_* producer channels (valid, data, ready);
//        out_valid/out_data/out_src/out_ready consumer side; level words held; full RAM full.
module ram16_arb_fifo
  import ram16_arb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  input  logic                  out_ready,
  output logic [DATA_DEPTH+1:0] level,
  output logic                  full
);

  localparam int DEPTH = 1 << DATA_DEPTH;
  localparam int RAM_W = DATA_WIDTH + 1;
  localparam logic [DATA_DEPTH-1:0] PTR_ONE = 1;
  localparam logic [DATA_DEPTH:0]   CNT_ONE = 1;
  localparam logic [DATA_DEPTH:0]   CNT_FULL = DEPTH[DATA_DEPTH:0];

  logic [DATA_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_DEPTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_src_q, out_src_d;
  logic                  rr_q, rr_d;
  logic                  full_q, full_d;
  logic [DATA_DEPTH+1:0] level_q, level_d;

  logic                  grant_any;
  src_e                  grant_src;
  logic                  grant0, grant1;
  logic                  load;
  logic [RAM_W-1:0]      ram_d;
  logic [RAM_W-1:0]      ram_qr;
  logic [RAM_W-1:0]      ram_qw_unused;

  // Grant uses only registered full, so a same-cycle load never opens a slot.
  assign grant_any = rst_n && !full_q && (req0_valid || req1_valid);
  assign grant_src = arb_pick(req0_valid, req1_valid, rr_q);
  assign grant0    = grant_any && (grant_src == SRC_CH0);
  assign grant1    = grant_any && (grant_src == SRC_CH1);
  assign ram_d     = grant1 ? {1'b1, req1_data} : {1'b0, req0_data};

  assign load = (ram_cnt_q != '0) && (!out_valid_q || out_ready);

  myRAM_WxD_D #(
    .DATA_WIDTH(RAM_W),
    .DATA_DEPTH(DATA_DEPTH)
  ) u_ram (
    .clk_i (clk),
    .we_i  (grant_any),
    .aw_i  (wr_ptr_q),
    .ar_i  (rd_ptr_q),
    .d_i   (ram_d),
    .qw_o  (ram_qw_unused),
    .qr_o  (ram_qr)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;

    if (grant_any) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      // Loser of this write gets priority next time.
      rr_d     = ~grant_src;
    end

    if (load) begin
      out_data_d  = ram_qr[DATA_WIDTH-1:0];
      out_src_d   = ram_qr[DATA_WIDTH];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({grant_any, load})
      2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    full_d  = (ram_cnt_d == CNT_FULL);
    level_d = {1'b0, ram_cnt_d} + {{(DATA_DEPTH+1){1'b0}}, out_valid_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      rr_q        <= 1'b0;
      full_q      <= 1'b0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
      full_q      <= full_d;
      level_q     <= level_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign level      = level_q;
  assign full       = full_q;

endmodule
